// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divide controller.
//   state_e     : controller state (idle, running, stopping at end of period)
//   DIV_W_DEF   : default divisor/counter width
//   MIN_DIVISOR : smallest divisor that yields a valid two-phase waveform
package clkdiv_pkg;

    localparam int unsigned DIV_W_DEF   = 28;
    localparam int unsigned MIN_DIVISOR = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } state_e;

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// Divisor configuration channel (valid/ready) plus the error pulse back to the master.
//   cfg_valid   : master offers cfg_divisor
//   cfg_divisor : offered period length in input-clock cycles
//   cfg_ready   : controller can accept a divisor
//   cfg_err     : one-cycle pulse after an accepted divisor below the minimum
interface clkdiv_ctrl_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) ();

    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_divisor;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_divisor,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_divisor,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clkdiv_period_cnt.sv
// Period counter and waveform compare for the clock divider.
//   clock_in, reset : clock and asynchronous active-high reset
//   enable_i        : counting in the current cycle (controller not idle)
//   active_div_i    : divisor governing the current period
//   next_en_i       : controller will be counting next cycle
//   next_div_i      : divisor in force next cycle
//   wrap_o          : current cycle is the last of the period
//   clock_out_o     : registered divided clock
//   tick_o          : registered pulse in the first high cycle
module clkdiv_period_cnt
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] active_div_i,
    input  logic             next_en_i,
    input  logic [DIV_W-1:0] next_div_i,
    output logic             wrap_o,
    output logic             clock_out_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half;
    logic             wrap;
    logic             clock_out_q, clock_out_d;
    logic             tick_q, tick_d;

    always_comb begin
        // Compare against div - 1 so an all-ones divisor cannot overflow the counter.
        wrap  = enable_i && (cnt_q == (active_div_i - DIV_W'(1)));
        cnt_d = '0;
        if (enable_i && !wrap) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // Outputs are computed from next-cycle values so they line up with the counter.
        half        = next_div_i >> 1;
        clock_out_d = next_en_i && (cnt_d >= half);
        tick_d      = next_en_i && (cnt_d == half);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
        end
    end

    assign wrap_o      = wrap;
    assign clock_out_o = clock_out_q;
    assign tick_o      = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run/stop and divisor-configuration controller for the clock divider.
//   clock_in, reset : clock and asynchronous active-high reset
//   run             : level request; 0 stops at the end of the current period
//   cfg             : divisor valid/ready channel (slave side) with error pulse
//   clock_out, tick : registered divided clock and first-high-cycle pulse
//   busy            : running or stopping
//   period_cnt      : saturating count of completed periods, only when
//                     CLKDIV_CTRL_STATUS_EN is defined
// New divisors sit in a one-entry pending register and take effect only at a
// period boundary (or immediately while idle) so no half-period is distorted.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned      DIV_W           = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEFAULT_DIVISOR = DIV_W'(2)
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         run,
    clkdiv_ctrl_if.slave cfg,
    output logic         clock_out,
    output logic         tick,
    output logic         busy
`ifdef CLKDIV_CTRL_STATUS_EN
    ,
    output logic [15:0]  period_cnt
`endif
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             wrap;
    logic             xfer;
    logic             apply;

    always_comb begin
        state_d      = state_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = 1'b0;

        xfer  = cfg.cfg_valid && !pend_valid_q;
        apply = pend_valid_q && ((state_q == StIdle) || wrap);

        if (apply) begin
            active_div_d = pend_div_q;
            pend_valid_d = 1'b0;
        end
        // xfer and apply are exclusive: accepting requires the pending slot to be empty.
        if (xfer) begin
            if (cfg.cfg_divisor < DIV_W'(MIN_DIVISOR)) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_div_d   = cfg.cfg_divisor;
            end
        end

        case (state_q)
            StIdle: begin
                if (run) state_d = StRun;
            end
            StRun: begin
                if (!run) state_d = StStopping;
            end
            StStopping: begin
                // A renewed request keeps the waveform going without a gap.
                if (run) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            active_div_q <= DEFAULT_DIVISOR;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    clkdiv_period_cnt #(
        .DIV_W(DIV_W)
    ) u_period_cnt (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable_i    (state_q != StIdle),
        .active_div_i(active_div_q),
        .next_en_i   (state_d != StIdle),
        .next_div_i  (active_div_d),
        .wrap_o      (wrap),
        .clock_out_o (clock_out),
        .tick_o      (tick)
    );

    assign cfg.cfg_ready = !pend_valid_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign busy          = (state_q != StIdle);

`ifdef CLKDIV_CTRL_STATUS_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (wrap && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: vector table, directed corner sequences
// and random stimulus against a cycle-level behavioural model.
module tb_clkdiv_ctrl;

    logic clock_in = 1'b0;
    logic reset;
    logic run;
    logic clock_out;
    logic tick;
    logic busy;
`ifdef CLKDIV_CTRL_STATUS_EN
    logic [15:0] period_cnt;
`endif

    clkdiv_ctrl_if #(.DIV_W(28)) cfg_if ();

    clkdiv_ctrl #(
        .DIV_W          (28),
        .DEFAULT_DIVISOR(28'd2)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .run       (run),
        .cfg       (cfg_if.slave),
        .clock_out (clock_out),
        .tick      (tick),
        .busy      (busy)
`ifdef CLKDIV_CTRL_STATUS_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the period, divisor in force, pending queue.
    bit          m_on;
    bit          m_stop;
    int unsigned m_pos;
    int unsigned m_div;
    int unsigned m_pend[$];
    bit          m_err;

    task automatic model_reset();
        m_on   = 1'b0;
        m_stop = 1'b0;
        m_pos  = 0;
        m_div  = 2;
        m_pend.delete();
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit v, input int unsigned d);
        bit          last;
        int unsigned nd;
        last  = m_on && (m_pos == m_div - 1);
        nd    = m_div;
        m_err = 1'b0;
        if (m_pend.size() != 0) begin
            if (!m_on || last) nd = m_pend.pop_front();
        end else if (v) begin
            if (d < 2) m_err = 1'b1;
            else m_pend.push_back(d);
        end
        if (!m_on) begin
            m_pos = 0;
            if (r) begin
                m_on   = 1'b1;
                m_stop = 1'b0;
            end
        end else if (m_stop && !r && last) begin
            m_on  = 1'b0;
            m_pos = 0;
        end else begin
            m_pos  = last ? 0 : m_pos + 1;
            m_stop = !r;
        end
        m_div = nd;
    endtask

    task automatic check_model();
        check("clock_out", int'(clock_out), int'(m_on && (m_pos >= m_div / 2)));
        check("tick", int'(tick), int'(m_on && (m_pos == m_div / 2)));
        check("busy", int'(busy), int'(m_on));
        check("cfg_ready", int'(cfg_if.cfg_ready), int'(m_pend.size() == 0));
        check("cfg_err", int'(cfg_if.cfg_err), int'(m_err));
    endtask

    task automatic step(input bit r, input bit v, input int unsigned d);
        run                = r;
        cfg_if.cfg_valid   = v;
        cfg_if.cfg_divisor = d[27:0];
        model_step(r, v, d);
        @(posedge clock_in);
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        reset              = 1'b1;
        run                = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_divisor = '0;
        model_reset();
        #1;
        check_model();
        @(posedge clock_in);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
    endtask

    // exp bits: {clock_out, tick, busy, cfg_ready, cfg_err}
    typedef struct {
        bit          run;
        bit          valid;
        int unsigned div;
        logic [4:0]  exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        int         n;
        logic [5:0] obs6;
        logic [9:0] obs10;
        bit         r_run;

        // Default divisor 2, then stop; divisor 5; rejected divisors 1 and 0.
        tbl[0]  = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[1]  = '{1'b1, 1'b0, 0, 5'b11110};
        tbl[2]  = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[3]  = '{1'b1, 1'b0, 0, 5'b11110};
        tbl[4]  = '{1'b0, 1'b0, 0, 5'b00110};
        tbl[5]  = '{1'b0, 1'b0, 0, 5'b11110};
        tbl[6]  = '{1'b0, 1'b0, 0, 5'b00010};
        tbl[7]  = '{1'b0, 1'b1, 5, 5'b00000};
        tbl[8]  = '{1'b0, 1'b0, 0, 5'b00010};
        tbl[9]  = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[10] = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[11] = '{1'b1, 1'b0, 0, 5'b11110};
        tbl[12] = '{1'b1, 1'b0, 0, 5'b10110};
        tbl[13] = '{1'b1, 1'b0, 0, 5'b10110};
        tbl[14] = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[15] = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[16] = '{1'b1, 1'b0, 0, 5'b11110};
        tbl[17] = '{1'b1, 1'b1, 1, 5'b10111};
        tbl[18] = '{1'b1, 1'b1, 0, 5'b10111};
        tbl[19] = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[20] = '{1'b1, 1'b0, 0, 5'b00110};
        tbl[21] = '{1'b1, 1'b0, 0, 5'b11110};

        apply_reset();
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].run, tbl[i].valid, tbl[i].div);
            check($sformatf("tbl%0d_clock_out", i), int'(clock_out), int'(tbl[i].exp[4]));
            check($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].exp[3]));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].exp[2]));
            check($sformatf("tbl%0d_ready", i), int'(cfg_if.cfg_ready), int'(tbl[i].exp[1]));
            check($sformatf("tbl%0d_err", i), int'(cfg_if.cfg_err), int'(tbl[i].exp[0]));
        end

        // D=4 running, D=6 offered at counter 1: ready low for counters 2 and 3,
        // then a 3-low/3-high period.
        apply_reset();
        step(0, 1, 4);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 6);
        n = 0;
        while (!cfg_if.cfg_ready && n < 10) begin
            n++;
            step(1, 0, 0);
        end
        check("reconfig_ready_low_cycles", n, 2);
        obs6 = {5'b0, clock_out};
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            obs6 = {obs6[4:0], clock_out};
        end
        check("reconfig_new_period", int'(obs6), int'(6'b000111));

        // D=8, run dropped at counter 1: six more cycles, then idle.
        apply_reset();
        step(0, 1, 8);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        n = 0;
        while (busy && n < 20) begin
            n++;
            step(0, 0, 0);
        end
        check("stop_tail_cycles", n, 6);
        check("stop_clock_low", int'(clock_out), 0);

        // Same, but run reasserted at counter 5: waveform continues without a gap.
        apply_reset();
        step(0, 1, 8);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(1, 0, 0);
        obs10 = {9'b0, clock_out};
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            obs10 = {obs10[8:0], clock_out};
        end
        check("resume_waveform", int'(obs10), int'(10'b1100001111));
        check("resume_busy", int'(busy), 1);

        // Start and transfer in the same idle cycle: first period uses the old divisor.
        apply_reset();
        step(1, 1, 4);
        check("start_xfer_ready", int'(cfg_if.cfg_ready), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);

        // Reset at counter 3 of D=10 with D=7 pending; afterwards the default divisor.
        apply_reset();
        step(0, 1, 10);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 7);
        apply_reset();
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(cfg_if.cfg_ready), 1);
        step(1, 0, 0);
        step(1, 0, 0);
        check("postreset_high", int'(clock_out), 1);
        step(1, 0, 0);
        check("postreset_period2", int'(clock_out), 0);

        // Largest divisor: counter must start cleanly without overflow.
        apply_reset();
        step(0, 1, 28'hFFFFFFF);
        step(0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Random run/config traffic against the model.
        apply_reset();
        r_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) r_run = !r_run;
            step(r_run, $urandom_range(0, 2) == 0, $urandom_range(0, 9));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
